mdu_iterative: RTL and testbench



---
 rtl/mdu_iterative.sv | 179 +++++++++++++++++
 tb/tb_mdu_iterative.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit sitting beside the EX-stage ALU.
//
// A one-cycle start pulse with a mult/div opcode captures the operands and computes the
// 64-bit result into a pending register. busy is then held for a fixed number of cycles,
// after which the pending value commits to HI/LO. MTHI/MTLO write HI/LO directly when idle,
// and MFHI/MFLO read them combinationally on MDUresult.
//
// Optional feature macro: MDU_MADD_EN adds MADD (1001) and MADDU (1010), which accumulate
// the product into {HI,LO} at commit. Without it those opcodes are NOPs.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   start      one-cycle pulse launching the operation on MDUop
//   MDUop      operation select (see OP_* constants)
//   SRCA       rs operand / dividend / MTHI-MTLO data
//   SRCB       rt operand / divisor
//   busy       high while an operation is in flight
//   HI, LO     architectural HI/LO registers
//   MDUresult  HI for MFHI, LO for MFLO, else 0
module mdu_iterative #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUop,
    input  logic [31:0] SRCA,
    input  logic [31:0] SRCB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUresult
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MFHI  = 4'b0111;
    localparam logic [3:0] OP_MFLO  = 4'b1000;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MADDU = 4'b1010;
`endif

    logic [0:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   hilo_q;
    logic [63:0]   pend_q, pend_d;
    logic          wr_q, wr_d;      // cleared when the divisor was zero: HI/LO keep old value
`ifdef MDU_MADD_EN
    logic          acc_q, acc_d;
`endif

    logic mul_op, div_op, madd_op, long_op, commit, launch, move_ok;
    logic [63:0] prod_s, prod_u, commit_val;
    logic        a_neg, b_neg;
    logic [31:0] ua, ub, uq, ur, quot, rem;

    assign busy = (state_q == RUN);
    assign HI   = hilo_q[63:32];
    assign LO   = hilo_q[31:0];

    assign mul_op = (MDUop == OP_MULT) || (MDUop == OP_MULTU);
    assign div_op = (MDUop == OP_DIV) || (MDUop == OP_DIVU);
`ifdef MDU_MADD_EN
    assign madd_op = (MDUop == OP_MADD) || (MDUop == OP_MADDU);
`else
    assign madd_op = 1'b0;
`endif
    assign long_op = mul_op || div_op || madd_op;

    assign commit  = busy && (cnt_q == CW'(1));
    // A new mult/div may launch on the edge where the previous one commits.
    assign launch  = start && long_op && (!busy || commit);
    assign move_ok = start && !busy;

    assign prod_s = $signed({{32{SRCA[31]}}, SRCA}) * $signed({{32{SRCB[31]}}, SRCB});
    assign prod_u = {32'b0, SRCA} * {32'b0, SRCB};

    // Signed divide on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
    assign a_neg = (MDUop == OP_DIV) && SRCA[31];
    assign b_neg = (MDUop == OP_DIV) && SRCB[31];
    assign ua    = a_neg ? (32'd0 - SRCA) : SRCA;
    assign ub    = (SRCB == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - SRCB) : SRCB);
    assign uq    = ua / ub;
    assign ur    = ua % ub;
    assign quot  = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign rem   = a_neg ? (32'd0 - ur) : ur;

    always_comb begin
        pend_d = pend_q;
        wr_d   = wr_q;
`ifdef MDU_MADD_EN
        acc_d  = acc_q;
`endif
        if (launch) begin
            wr_d = 1'b1;
`ifdef MDU_MADD_EN
            acc_d = madd_op;
`endif
            if ((MDUop == OP_MULT)
`ifdef MDU_MADD_EN
                || (MDUop == OP_MADD)
`endif
               ) begin
                pend_d = prod_s;
            end else if (div_op) begin
                pend_d = {rem, quot};
                wr_d   = (SRCB != 32'd0);
            end else begin
                pend_d = prod_u;
            end
        end
    end

`ifdef MDU_MADD_EN
    assign commit_val = acc_q ? (hilo_q + pend_q) : pend_q;
`else
    assign commit_val = pend_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hilo_q  <= '0;
            pend_q  <= '0;
            wr_q    <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q   <= 1'b0;
`endif
        end else begin
            if (launch) begin
                state_q <= RUN;
                cnt_q   <= div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (commit) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q - CW'(1);
            end

            pend_q <= pend_d;
            wr_q   <= wr_d;
`ifdef MDU_MADD_EN
            acc_q  <= acc_d;
`endif

            if (commit && wr_q) begin
                hilo_q <= commit_val;
            end else if (move_ok && (MDUop == OP_MTHI)) begin
                hilo_q[63:32] <= SRCA;
            end else if (move_ok && (MDUop == OP_MTLO)) begin
                hilo_q[31:0] <= SRCA;
            end
        end
    end

    always_comb begin
        MDUresult = 32'd0;
        if (MDUop == OP_MFHI) begin
            MDUresult = HI;
        end else if (MDUop == OP_MFLO) begin
            MDUresult = LO;
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (default parameters 5/10 cycles).
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  MDUop = 4'd0;
    logic [31:0] SRCA = 32'd0;
    logic [31:0] SRCB = 32'd0;
    logic        busy;
    logic [31:0] HI, LO, MDUresult;

    int checks = 0;
    int errors = 0;

    mdu_iterative dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MDUop     (MDUop),
        .SRCA      (SRCA),
        .SRCB      (SRCB),
        .busy      (busy),
        .HI        (HI),
        .LO        (LO),
        .MDUresult (MDUresult)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge; returns at the negedge after that edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; MDUop = op; SRCA = a; SRCB = b;
        @(negedge clk);
        start = 1'b0; MDUop = 4'd0;
    endtask

    // Counts negedges at which busy is high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        MDUop = 4'b0111; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", LO); end
        checks++; if (MDUresult !== 32'd0) begin errors++; $display("FAIL reset_mfhi got %h want 0", MDUresult); end
        MDUop = 4'd0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_mult;
        int n;
        issue(4'b0001, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_latency got %0d want 5", n); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", LO); end
        MDUop = 4'b0111; #1;
        checks++; if (MDUresult !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mfhi got %h want ffffffff", MDUresult); end
        MDUop = 4'b1000; #1;
        checks++; if (MDUresult !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mflo got %h want fffffffa", MDUresult); end
        MDUop = 4'b0000; #1;
        checks++; if (MDUresult !== 32'd0) begin errors++; $display("FAIL nop_result got %h want 0", MDUresult); end
    endtask

    task automatic test_multu;
        int n;
        issue(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL multu_latency got %0d want 5", n); end
        checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", HI); end
        checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 1", LO); end
    endtask

    task automatic test_div;
        int n;
        issue(4'b0011, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL div_latency got %0d want 10", n); end
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", HI); end
        issue(4'b0100, 32'd7, 32'd0);
        wait_idle(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divz_latency got %0d want 10", n); end
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divz_lo got %h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_hi got %h want ffffffff", HI); end
        issue(4'b0011, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL divovf_hi got %h want 0", HI); end
        issue(4'b0100, 32'd100, 32'd7);
        wait_idle(n);
        checks++; if (LO !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want e", LO); end
        checks++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 2", HI); end
    endtask

    task automatic test_mthi;
        int n;
        issue(4'b0101, 32'h1234_5678, 32'd0);
        checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", HI); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %h want 0", busy); end
        issue(4'b0001, 32'd6, 32'd7);
        start = 1'b1; MDUop = 4'b0110; SRCA = 32'hDEAD_BEEF;
        @(negedge clk);
        MDUop = 4'b0001; SRCA = 32'd2; SRCB = 32'd2;
        @(negedge clk);
        start = 1'b0; MDUop = 4'b0111; #1;
        checks++; if (MDUresult !== 32'h1234_5678) begin errors++; $display("FAIL mfhi_busy got %h want 12345678", MDUresult); end
        MDUop = 4'd0;
        wait_idle(n);
        checks++; if (LO !== 32'd42) begin errors++; $display("FAIL ignored_lo got %h want 2a", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL ignored_hi got %h want 0", HI); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy got %h want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(4'b0001, 32'hFFFF_FFFF, 32'd5);
        repeat (4) @(negedge clk);
        // Present the next op at the edge where the first one commits.
        start = 1'b1; MDUop = 4'b0010; SRCA = 32'd3; SRCB = 32'd4;
        @(negedge clk);
        start = 1'b0; MDUop = 4'd0;
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_first_hi got %h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFB) begin errors++; $display("FAIL b2b_first_lo got %h want fffffffb", LO); end
        wait_idle(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", n); end
        checks++; if (LO !== 32'd12) begin errors++; $display("FAIL b2b_lo got %h want c", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL b2b_hi got %h want 0", HI); end
    endtask

    task automatic test_reset_mid;
        int n;
        issue(4'b0101, 32'hAAAA_5555, 32'd0);
        issue(4'b0011, 32'hFFFF_FFF9, 32'd2);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %h want 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rstmid_hi got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL rstmid_lo got %h want 0", LO); end
        #1 reset = 1'b0;
        issue(4'b0001, 32'd4, 32'd5);
        wait_idle(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL rstmul_latency got %0d want 5", n); end
        checks++; if (LO !== 32'd20) begin errors++; $display("FAIL rstmul_lo got %h want 14", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rstmul_hi got %h want 0", HI); end
    endtask

    task automatic test_madd;
        int n;
        issue(4'b0101, 32'd0, 32'd0);
        issue(4'b0110, 32'hFFFF_FFFF, 32'd0);
        issue(4'b1010, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_idle(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL maddu_latency got %0d want 5", n); end
        checks++; if (HI !== 32'd1) begin errors++; $display("FAIL maddu_hi got %h want 1", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL maddu_lo got %h want 0", LO); end
        issue(4'b0101, 32'd0, 32'd0);
        issue(4'b0110, 32'd5, 32'd0);
        issue(4'b1001, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        checks++; if (LO !== 32'd3) begin errors++; $display("FAIL madd_lo got %h want 3", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL madd_hi got %h want 0", HI); end
`else
        n = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL maddu_nop_busy got %h want 0", busy); end
        wait_idle(n);
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL maddu_nop_hi got %h want 0", HI); end
        checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL maddu_nop_lo got %h want ffffffff", LO); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi();
        test_back_to_back();
        test_reset_mid();
        test_madd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
